gol_gen_scheduler: RTL and testbench

// - Sequences the Game of Life board engine: decides when a generation runs, drives copy/compute phases,

---
 rtl/gol_pkg.sv | 32 +++
 rtl/gol_frame_divider.sv | 28 ++
 rtl/gol_gen_scheduler.sv | 157 +++++++++++++++
 tb/tb_gol_gen_scheduler.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gol_pkg.sv
// Shared types and constants for the Game of Life generation scheduler.
package gol_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LD_START,
    S_LD_WAIT,
    S_CP_START,
    S_CP_WAIT,
    S_CM_START,
    S_CM_WAIT
  } state_t;

  localparam logic [1:0] OP_COPY    = 2'd0;
  localparam logic [1:0] OP_COMPUTE = 2'd1;
  localparam logic [1:0] OP_LOAD    = 2'd2;

  localparam int BOARD_CELLS = 64;

  // Last divider count before a wrap: frames per generation minus one.
  function automatic logic [2:0] speed_limit(input logic [1:0] speed);
    logic [2:0] lim;
    case (speed)
      2'd0:    lim = 3'd0;
      2'd1:    lim = 3'd1;
      2'd2:    lim = 3'd3;
      default: lim = 3'd7;
    endcase
    return lim;
  endfunction

endpackage

// File: rtl/gol_frame_divider.sv
// Frame divider: counts frame ticks and pulses wrap (same cycle as the tick) every 1<<speed frames.
module gol_frame_divider
  import gol_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       run_en,
  input  logic [1:0] speed,
  output logic       wrap
);

  logic [2:0] count;

  // >= so a count left above a newly lowered limit wraps on the next tick.
  assign wrap = frame_tick && run_en && (count >= speed_limit(speed));

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= 3'd0;
    end else if (!run_en) begin
      count <= 3'd0;
    end else if (frame_tick) begin
      count <= wrap ? 3'd0 : count + 3'd1;
    end
  end

endmodule

// File: rtl/gol_gen_scheduler.sv
// Game of Life generation scheduler: arbitrates load/free-run/step requests on frame ticks and
// sequences COPY then COMPUTE (or LOAD) commands to the board engine with a watchdog.
module gol_gen_scheduler
  import gol_pkg::*;
#(
  parameter int GEN_W       = 16,
  parameter int TIMEOUT_CYC = 1024,
  parameter int OVR_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             frame_tick,
  input  logic             run_en,
  input  logic             step_btn,
  input  logic             load_btn,
  input  logic [1:0]       speed,
  input  logic             engine_done,
  output logic             engine_start,
  output logic [1:0]       engine_op,
  output logic             vga_source,
  output logic [GEN_W-1:0] gen_count,
  output logic             gen_pulse,
  output logic             busy,
  output logic [OVR_W-1:0] overrun,
  output logic             timeout_err
);

  localparam int WD_W = $clog2(TIMEOUT_CYC) + 1;

  state_t          state;
  logic            step_prev, load_prev;
  logic            step_pend, load_pend, gen_due;
  logic [WD_W-1:0] wd;
  logic            wrap;

  gol_frame_divider u_div (
    .clk        (clk),
    .reset      (reset),
    .frame_tick (frame_tick),
    .run_en     (run_en),
    .speed      (speed),
    .wrap       (wrap)
  );

  // A request arriving in the tick cycle itself is served on that tick.
  logic step_req, load_req, gen_req, idle_eval;
  logic take_load, take_gen, take_step, drop, wd_exp;

  assign step_req  = step_pend | (step_btn & ~step_prev);
  assign load_req  = load_pend | (load_btn & ~load_prev);
  assign gen_req   = gen_due | wrap;
  assign idle_eval = (state == S_IDLE) && frame_tick;
  assign take_load = idle_eval && load_req;
  assign take_gen  = idle_eval && !load_req && gen_req;
  assign take_step = idle_eval && !load_req && !gen_req && step_req && !run_en;
  assign drop      = wrap && gen_due;
  assign wd_exp    = (wd == WD_W'(TIMEOUT_CYC - 1));

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      step_prev    <= 1'b0;
      load_prev    <= 1'b0;
      step_pend    <= 1'b0;
      load_pend    <= 1'b0;
      gen_due      <= 1'b0;
      wd           <= '0;
      engine_start <= 1'b0;
      engine_op    <= OP_COPY;
      vga_source   <= 1'b0;
      gen_count    <= '0;
      gen_pulse    <= 1'b0;
      overrun      <= '0;
      timeout_err  <= 1'b0;
    end else begin
      step_prev    <= step_btn;
      load_prev    <= load_btn;
      engine_start <= 1'b0;
      gen_pulse    <= 1'b0;

      load_pend <= take_load ? 1'b0 : load_req;
      step_pend <= (take_step || (idle_eval && run_en)) ? 1'b0 : step_req;
      gen_due   <= take_gen ? 1'b0 : gen_req;
      if (drop && (overrun != '1)) overrun <= overrun + OVR_W'(1);

      case (state)
        S_IDLE: begin
          if (take_load) begin
            state        <= S_LD_START;
            engine_start <= 1'b1;
            engine_op    <= OP_LOAD;
          end else if (take_gen || take_step) begin
            state        <= S_CP_START;
            engine_start <= 1'b1;
            engine_op    <= OP_COPY;
          end
        end
        S_LD_START: begin
          state <= S_LD_WAIT;
          wd    <= '0;
        end
        S_CP_START: begin
          state <= S_CP_WAIT;
          wd    <= '0;
        end
        S_CM_START: begin
          state <= S_CM_WAIT;
          wd    <= '0;
        end
        S_LD_WAIT: begin
          if (engine_done) begin
            state       <= S_IDLE;
            gen_count   <= '0;
            timeout_err <= 1'b0;
          end else if (wd_exp) begin
            state       <= S_IDLE;
            timeout_err <= 1'b1;
          end else begin
            wd <= wd + WD_W'(1);
          end
        end
        S_CP_WAIT: begin
          if (engine_done) begin
            state        <= S_CM_START;
            engine_start <= 1'b1;
            engine_op    <= OP_COMPUTE;
            vga_source   <= 1'b1;
          end else if (wd_exp) begin
            state       <= S_IDLE;
            timeout_err <= 1'b1;
          end else begin
            wd <= wd + WD_W'(1);
          end
        end
        S_CM_WAIT: begin
          // Done coinciding with watchdog expiry still completes the generation.
          if (engine_done) begin
            state      <= S_IDLE;
            gen_count  <= gen_count + GEN_W'(1);
            gen_pulse  <= 1'b1;
            vga_source <= 1'b0;
          end else if (wd_exp) begin
            state       <= S_IDLE;
            timeout_err <= 1'b1;
            vga_source  <= 1'b0;
          end else begin
            wd <= wd + WD_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gol_gen_scheduler.sv
// Bench for gol_gen_scheduler: divider table plus directed load/step/timeout/overrun/reset sequences.
module tb_gol_gen_scheduler;
  import gol_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        frame_tick = 1'b0;
  logic        run_en = 1'b0;
  logic        step_btn = 1'b0;
  logic        load_btn = 1'b0;
  logic [1:0]  speed = 2'd0;
  logic        engine_done = 1'b0;
  logic        engine_start;
  logic [1:0]  engine_op;
  logic        vga_source;
  logic [15:0] gen_count;
  logic        gen_pulse;
  logic        busy;
  logic [7:0]  overrun;
  logic        timeout_err;

  int total = 0;
  int bad = 0;

  gol_gen_scheduler #(.GEN_W(16), .TIMEOUT_CYC(1024), .OVR_W(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .frame_tick   (frame_tick),
    .run_en       (run_en),
    .step_btn     (step_btn),
    .load_btn     (load_btn),
    .speed        (speed),
    .engine_done  (engine_done),
    .engine_start (engine_start),
    .engine_op    (engine_op),
    .vga_source   (vga_source),
    .gen_count    (gen_count),
    .gen_pulse    (gen_pulse),
    .busy         (busy),
    .overrun      (overrun),
    .timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;

  // Engine model: answers each start with a done pulse eng_lat cycles later.
  int         eng_lat = 70;
  bit         eng_en = 1'b1;
  int         eng_cnt = 0;
  int         pulse_cnt = 0;
  logic [1:0] op_q[$];

  always @(negedge clk) begin
    engine_done = 1'b0;
    if (reset) begin
      eng_cnt = 0;
    end else if (eng_cnt > 0) begin
      eng_cnt--;
      if (eng_cnt == 0) engine_done = 1'b1;
    end else if (engine_start && eng_en) begin
      eng_cnt = eng_lat;
    end
    if (engine_start) op_q.push_back(engine_op);
    if (gen_pulse) pulse_cnt++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tick();
    @(negedge clk) frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b0;
  endtask

  task automatic frame();
    tick();
    cycles(198);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    frame_tick = 1'b0;
    step_btn = 1'b0;
    load_btn = 1'b0;
    cycles(2);
    reset = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_start"}, engine_start, 0);
    chk({tag, "_op"}, engine_op, 0);
    chk({tag, "_vga"}, vga_source, 0);
    chk({tag, "_gen"}, gen_count, 0);
    chk({tag, "_pulse"}, gen_pulse, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_ovr"}, overrun, 0);
    chk({tag, "_tmo"}, timeout_err, 0);
  endtask

  typedef struct {
    logic [1:0] spd;
    logic       run;
    int         nticks;
    int         exp_gens;
    int         exp_ovr;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int n0;
    int p0;

    vecs[0] = '{2'd0, 1'b1, 4, 4, 0};
    vecs[1] = '{2'd1, 1'b1, 4, 2, 0};
    vecs[2] = '{2'd2, 1'b1, 12, 3, 0};
    vecs[3] = '{2'd3, 1'b1, 16, 2, 0};
    vecs[4] = '{2'd3, 1'b1, 7, 0, 0};
    vecs[5] = '{2'd0, 1'b0, 5, 0, 0};
    vecs[6] = '{2'd2, 1'b1, 3, 0, 0};

    cycles(3);
    reset = 1'b0;
    @(negedge clk);
    chk_all_zero("rst");

    // Free run at speed 0: latency, op sequence, display select.
    speed = 2'd0;
    run_en = 1'b1;
    n0 = op_q.size();
    p0 = pulse_cnt;
    tick();
    chk("start_lat", engine_start, 1);
    chk("op_copy", engine_op, OP_COPY);
    cycles(1);
    chk("start_1cyc", engine_start, 0);
    chk("busy_run", busy, 1);
    cycles(99);
    chk("cm_vga", vga_source, 1);
    chk("cm_op", engine_op, OP_COMPUTE);
    cycles(98);
    chk("gen1", gen_count, 1);
    chk("idle_busy", busy, 0);
    chk("idle_vga", vga_source, 0);
    chk("ops_n", op_q.size(), n0 + 2);
    chk("ops_0", op_q[n0], OP_COPY);
    chk("ops_1", op_q[n0+1], OP_COMPUTE);
    frame();
    chk("gen2", gen_count, 2);
    frame();
    chk("gen3", gen_count, 3);
    chk("pulses3", pulse_cnt - p0, 3);

    // Divider table.
    for (int i = 0; i < 7; i++) begin
      do_reset();
      speed = vecs[i].spd;
      run_en = vecs[i].run;
      p0 = pulse_cnt;
      repeat (vecs[i].nticks) frame();
      chk($sformatf("tbl%0d_gen", i), gen_count, vecs[i].exp_gens);
      chk($sformatf("tbl%0d_pulse", i), pulse_cnt - p0, vecs[i].exp_gens);
      chk($sformatf("tbl%0d_ovr", i), overrun, vecs[i].exp_ovr);
    end

    // Lowering speed with count already past the new limit wraps on the next tick.
    do_reset();
    speed = 2'd3;
    run_en = 1'b1;
    repeat (5) frame();
    chk("spd_pre", gen_count, 0);
    speed = 2'd1;
    frame();
    chk("spd_wrap", gen_count, 1);
    frame();
    frame();
    chk("spd_after", gen_count, 2);

    // Single step while stopped; a second edge while busy queues one more.
    do_reset();
    run_en = 1'b0;
    speed = 2'd0;
    frame();
    chk("step_none", gen_count, 0);
    step_btn = 1'b1;
    cycles(10);
    tick();
    chk("step_start", engine_start, 1);
    cycles(20);
    step_btn = 1'b0;
    cycles(5);
    step_btn = 1'b1;
    cycles(172);
    chk("step_gen1", gen_count, 1);
    frame();
    chk("step_gen2", gen_count, 2);
    frame();
    chk("step_hold", gen_count, 2);
    step_btn = 1'b0;

    // Load and generation due on the same tick: load first, generation next tick.
    do_reset();
    speed = 2'd1;
    run_en = 1'b1;
    frame();
    frame();
    chk("ld_pre_gen", gen_count, 1);
    frame();
    load_btn = 1'b1;
    cycles(5);
    n0 = op_q.size();
    tick();
    chk("ld_start", engine_start, 1);
    chk("ld_op", engine_op, OP_LOAD);
    cycles(198);
    chk("ld_clr", gen_count, 0);
    chk("ld_idle", busy, 0);
    frame();
    chk("ld_then_gen", gen_count, 1);
    chk("ld_ops_n", op_q.size(), n0 + 3);
    chk("ld_ops_0", op_q[n0], OP_LOAD);
    chk("ld_ops_1", op_q[n0+1], OP_COPY);
    chk("ld_ops_2", op_q[n0+2], OP_COMPUTE);
    chk("ld_ovr", overrun, 0);
    load_btn = 1'b0;

    // Watchdog: done withheld, abort exactly after TIMEOUT_CYC wait cycles.
    do_reset();
    run_en = 1'b0;
    eng_en = 1'b0;
    step_btn = 1'b1;
    cycles(3);
    tick();
    chk("wd_start", engine_start, 1);
    cycles(1024);
    chk("wd_edge_busy", busy, 1);
    chk("wd_edge_err", timeout_err, 0);
    cycles(1);
    chk("wd_idle", busy, 0);
    chk("wd_err", timeout_err, 1);
    chk("wd_vga", vga_source, 0);
    chk("wd_nogen", gen_count, 0);
    eng_en = 1'b1;
    load_btn = 1'b1;
    cycles(3);
    tick();
    chk("wd_sticky", timeout_err, 1);
    cycles(198);
    chk("wd_clr", timeout_err, 0);
    load_btn = 1'b0;
    step_btn = 1'b0;

    // Engine stalled across three further ticks at speed 0.
    do_reset();
    speed = 2'd0;
    run_en = 1'b1;
    eng_lat = 320;
    frame();
    frame();
    frame();
    tick();
    cycles(100);
    chk("ovr_cnt", overrun, 2);
    chk("ovr_gen", gen_count, 1);
    chk("ovr_idle", busy, 0);
    eng_lat = 70;

    // Reset in the middle of a COMPUTE.
    frame();
    tick();
    cycles(100);
    chk("mid_vga", vga_source, 1);
    chk("mid_busy", busy, 1);
    reset = 1'b1;
    @(negedge clk);
    chk_all_zero("mid_rst");
    cycles(2);
    reset = 1'b0;
    cycles(300);
    chk("post_busy", busy, 0);
    chk("post_gen", gen_count, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
